// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner: FSM encoding,
// row count and the (row, column) to hex key map.
package keypad_pkg;

  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  // Keypad legend: row3 carries '*' (E), '0', '#' (F) and 'D'.
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Index of the lowest-numbered active-low column; lowest index wins.
  function automatic logic [1:0] first_low(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cols[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (keypad columns,
// push-buttons). Resets to all-ones to match idle pulled-up lines.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: clocked state uses non-blocking assignments so both stages sample
  // the pre-edge values; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= {WIDTH{1'b1}};
      q    <= {WIDTH{1'b1}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the rows on scan_tick, debounces press
// and release, and reports the accepted key as a hex code.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_tick,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int RW = $clog2(NUM_ROWS);
  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_TICKS);

  state_t          state, state_nxt;
  logic [RW-1:0]   row_sel, row_sel_nxt, cap_row, cap_row_nxt;
  logic [3:0]      cap_cols, cap_cols_nxt;
  logic [3:0]      cnt, cnt_nxt, cnt_inc;
  logic [3:0]      sync_s;
  logic            accept;
  logic [3:0]      row_n_nxt, key_code_nxt;
  logic            key_valid_nxt, key_held_nxt;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (col_n),
    .q     (sync_s)
  );

  assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      row_sel   <= '0;
      cap_row   <= '0;
      cap_cols  <= 4'b1111;
      cnt       <= 4'd0;
      row_n     <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      row_sel   <= row_sel_nxt;
      cap_row   <= cap_row_nxt;
      cap_cols  <= cap_cols_nxt;
      cnt       <= cnt_nxt;
      row_n     <= row_n_nxt;
      key_code  <= key_code_nxt;
      key_valid <= key_valid_nxt;
      key_held  <= key_held_nxt;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    row_sel_nxt  = row_sel;
    cap_row_nxt  = cap_row;
    cap_cols_nxt = cap_cols;
    cnt_nxt      = cnt;
    accept       = 1'b0;
    if (scan_tick) begin
      unique case (state)
        SCAN: begin
          if (sync_s == 4'b1111) begin
            row_sel_nxt = row_sel + 1'b1;
          end else begin
            cap_row_nxt  = row_sel;
            cap_cols_nxt = sync_s;
            cnt_nxt      = 4'd1;
            state_nxt    = PRESS_DB;
          end
        end
        PRESS_DB: begin
          // Whole column pattern must match, so a second key mid-debounce restarts.
          if (sync_s == cap_cols) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc >= DB_LIMIT) begin
              accept    = 1'b1;
              state_nxt = HELD;
            end
          end else begin
            cnt_nxt   = 4'd0;
            state_nxt = SCAN;
          end
        end
        HELD: begin
          if (sync_s == 4'b1111) begin
            cnt_nxt   = 4'd1;
            state_nxt = REL_DB;
          end
        end
        REL_DB: begin
          if (sync_s == 4'b1111) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc >= DB_LIMIT) begin
              cnt_nxt     = 4'd0;
              row_sel_nxt = row_sel + 1'b1;
              state_nxt   = SCAN;
            end
          end else begin
            cnt_nxt   = 4'd0;
            state_nxt = HELD;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  always_comb begin
    row_n_nxt     = ~(4'b0001 << row_sel_nxt);
    key_valid_nxt = accept;
    key_code_nxt  = accept ? keymap(cap_row, first_low(cap_cols)) : key_code;
    key_held_nxt  = (state_nxt == HELD) || (state_nxt == REL_DB);
  end

endmodule
